// File: rtl/balance_seq.sv
// Balance-control sequencer: rider detection, steer-enable delay and latched
// overspeed fault, driving the PID and Segway-math enables.
module balance_seq #(
  parameter int unsigned FAST_SIM  = 1,
  parameter int unsigned RIDER_CNT = 8,
  parameter int unsigned OVS_CNT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auth_pwr,
  input  logic       rider_wt_ok,
  input  logic       sample_rdy,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic       rider_off,
  output logic       vld,
  output logic       en_steer,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    WAIT_RIDER = 3'd1,
    BALANCE    = 3'd2,
    STEER      = 3'd3,
    FAULT      = 3'd4
  } state_t;

  localparam int unsigned RW = $clog2(RIDER_CNT + 1);
  localparam int unsigned OW = $clog2(OVS_CNT + 1);
  localparam logic [RW-1:0] RIDER_TERM = RW'(RIDER_CNT);
  localparam logic [OW-1:0] OVS_TERM   = OW'(OVS_CNT);
  localparam logic [24:0]   STEER_LAST = (FAST_SIM != 0) ? 25'd1023 : 25'h1FF_FFFF;

  state_t        state_q, state_d;
  logic [RW-1:0] on_cnt_q, on_cnt_d, off_cnt_q, off_cnt_d, on_inc, off_inc;
  logic [OW-1:0] ovs_cnt_q, ovs_cnt_d, ovs_inc;
  logic [24:0]   timer_q, timer_d;
  logic          vld_q, vld_d;
  logic          on_hit, off_hit, ovs_hit;

  // Saturating increments; a "hit" is the sample that makes a counter reach terminal.
  always_comb begin
    on_inc  = (on_cnt_q  == RIDER_TERM) ? on_cnt_q  : on_cnt_q  + RW'(1);
    off_inc = (off_cnt_q == RIDER_TERM) ? off_cnt_q : off_cnt_q + RW'(1);
    ovs_inc = (ovs_cnt_q == OVS_TERM)   ? ovs_cnt_q : ovs_cnt_q + OW'(1);
    on_hit  = sample_rdy &&  rider_wt_ok && (on_inc  == RIDER_TERM);
    off_hit = sample_rdy && !rider_wt_ok && (off_inc == RIDER_TERM);
    ovs_hit = sample_rdy &&  too_fast    && (ovs_inc == OVS_TERM);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:        if (auth_pwr) state_d = WAIT_RIDER;
      WAIT_RIDER: begin
        if (!auth_pwr)   state_d = OFF;
        else if (on_hit) state_d = BALANCE;
      end
      BALANCE, STEER: begin
        if (ovs_hit)       state_d = FAULT;
        else if (off_hit)  state_d = auth_pwr ? WAIT_RIDER : OFF;
        else if (state_q == BALANCE && timer_q == STEER_LAST) state_d = STEER;
      end
      FAULT:      if (!auth_pwr) state_d = OFF;
      default:    state_d = OFF;
    endcase
  end

  always_comb begin
    on_cnt_d  = on_cnt_q;
    off_cnt_d = off_cnt_q;
    ovs_cnt_d = ovs_cnt_q;
    if (state_d != state_q) begin
      on_cnt_d  = '0;
      off_cnt_d = '0;
      ovs_cnt_d = '0;
    end else if (sample_rdy) begin
      on_cnt_d  = rider_wt_ok ? on_inc  : '0;
      off_cnt_d = rider_wt_ok ? '0      : off_inc;
      ovs_cnt_d = too_fast    ? ovs_inc : '0;
    end
    // Held at zero outside BALANCE, so entry always starts a fresh delay.
    timer_d = (state_q == BALANCE) ? timer_q + 25'd1 : '0;
    vld_d   = sample_rdy && (state_q == BALANCE || state_q == STEER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF;
      on_cnt_q  <= '0;
      off_cnt_q <= '0;
      ovs_cnt_q <= '0;
      timer_q   <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      off_cnt_q <= off_cnt_d;
      ovs_cnt_q <= ovs_cnt_d;
      timer_q   <= timer_d;
      vld_q     <= vld_d;
    end
  end

  always_comb begin
    pwr_up    = 1'b0;
    rider_off = 1'b1;
    en_steer  = 1'b0;
    fault     = 1'b0;
    unique case (state_q)
      WAIT_RIDER: pwr_up = 1'b1;
      BALANCE: begin
        pwr_up    = 1'b1;
        rider_off = 1'b0;
      end
      STEER: begin
        pwr_up    = 1'b1;
        rider_off = 1'b0;
        en_steer  = 1'b1;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  assign vld   = vld_q;
  assign state = state_q;

endmodule

// File: tb/tb_balance_seq.sv
// Scenario bench for balance_seq: expected state/vld per sample strobe are
// queued as stimulus is driven and popped once the clock edge has produced them.
module tb_balance_seq;

  logic       clk = 1'b0;
  logic       rst, auth_pwr, rider_wt_ok, sample_rdy, too_fast;
  logic       pwr_up, rider_off, vld, en_steer, fault;
  logic [2:0] state;

  typedef struct {
    logic [2:0] st;
    logic       v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   bal_entry = 0;

  balance_seq #(.FAST_SIM(1), .RIDER_CNT(8), .OVS_CNT(4)) dut (
    .clk(clk), .rst(rst), .auth_pwr(auth_pwr), .rider_wt_ok(rider_wt_ok),
    .sample_rdy(sample_rdy), .too_fast(too_fast), .pwr_up(pwr_up),
    .rider_off(rider_off), .vld(vld), .en_steer(en_steer), .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Moore output table {pwr_up, rider_off, en_steer, fault} by state.
  function automatic logic [3:0] outs(input logic [2:0] s);
    case (s)
      3'd0:    return 4'b0100;
      3'd1:    return 4'b1100;
      3'd2:    return 4'b1000;
      3'd3:    return 4'b1010;
      3'd4:    return 4'b0101;
      default: return 4'bxxxx;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rw, input logic tf, input logic [2:0] st,
                        input logic v, input string nm);
    sb.push_back('{st: st, v: v, nm: nm});
    rider_wt_ok = rw;
    too_fast    = tf;
    sample_rdy  = 1'b1;
    tick();
    sample_rdy  = 1'b0;
  endtask

  // Drives OFF/WAIT -> BALANCE -> STEER without checking; callers check the end state.
  task automatic reach_steer();
    auth_pwr = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0, 3'd0, 1'b0, "unused");
    sb.delete();
    bal_entry = cyc;
    while (cyc - bal_entry < 1024) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; auth_pwr = 1'b0; rider_wt_ok = 1'b0; sample_rdy = 1'b0; too_fast = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({state, vld} !== 4'b0000 || {pwr_up, rider_off, en_steer, fault} !== outs(3'd0)) begin
      n_err++;
      $display("FAIL reset: state=%0d vld=%b outs=%b, expected state=0 vld=0 outs=%b",
               state, vld, {pwr_up, rider_off, en_steer, fault}, outs(3'd0));
    end
    rst = 1'b0;
  endtask

  task automatic test_power_on();
    auth_pwr = 1'b1;
    tick();
    n_cmp++;
    if (state !== 3'd1 || {pwr_up, rider_off, en_steer, fault} !== outs(3'd1)) begin
      n_err++;
      $display("FAIL wait_entry: state=%0d outs=%b, expected state=1 outs=%b",
               state, {pwr_up, rider_off, en_steer, fault}, outs(3'd1));
    end
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, 1'b0, (i == 7) ? 3'd2 : 3'd1, 1'b0, "rider_on");
      e = sb.pop_front();
      n_cmp++;
      if (state !== e.st || vld !== e.v) begin
        n_err++;
        $display("FAIL %s[%0d]: state=%0d vld=%b, expected state=%0d vld=%b",
                 e.nm, i, state, vld, e.st, e.v);
      end
    end
    bal_entry = cyc;
    n_cmp++;
    if ({pwr_up, rider_off, en_steer, fault} !== outs(3'd2)) begin
      n_err++;
      $display("FAIL balance_outs: outs=%b, expected %b",
               {pwr_up, rider_off, en_steer, fault}, outs(3'd2));
    end
    strobe(1'b1, 1'b0, 3'd2, 1'b1, "vld_latency");
    e = sb.pop_front();
    n_cmp++;
    if (state !== e.st || vld !== e.v) begin
      n_err++;
      $display("FAIL %s: state=%0d vld=%b, expected state=%0d vld=%b",
               e.nm, state, vld, e.st, e.v);
    end
    tick();
    n_cmp++;
    if (vld !== 1'b0) begin
      n_err++;
      $display("FAIL vld_single: vld=%b, expected 0", vld);
    end
  endtask

  task automatic test_steer_timer();
    while (cyc - bal_entry < 1023) tick();
    n_cmp++;
    if (state !== 3'd2) begin
      n_err++;
      $display("FAIL steer_early: state=%0d, expected 2", state);
    end
    tick();
    n_cmp++;
    if (state !== 3'd3 || en_steer !== 1'b1 || {pwr_up, rider_off, fault} !== 3'b100) begin
      n_err++;
      $display("FAIL steer_entry: state=%0d en_steer=%b, expected state=3 en_steer=1",
               state, en_steer);
    end
  endtask

  task automatic test_fault();
    logic [7:0] tf_pat;
    tf_pat = 8'b1111_0111;
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, tf_pat[i], (i == 7) ? 3'd4 : 3'd3, 1'b1, "overspeed");
      e = sb.pop_front();
      n_cmp++;
      if (state !== e.st || vld !== e.v) begin
        n_err++;
        $display("FAIL %s[%0d]: state=%0d vld=%b, expected state=%0d vld=%b",
                 e.nm, i, state, vld, e.st, e.v);
      end
    end
    too_fast = 1'b0;
    n_cmp++;
    if ({pwr_up, rider_off, en_steer, fault} !== outs(3'd4)) begin
      n_err++;
      $display("FAIL fault_outs: outs=%b, expected %b",
               {pwr_up, rider_off, en_steer, fault}, outs(3'd4));
    end
    strobe(1'b1, 1'b0, 3'd4, 1'b0, "fault_hold");
    e = sb.pop_front();
    repeat (3) tick();
    n_cmp++;
    if (state !== e.st || vld !== e.v) begin
      n_err++;
      $display("FAIL %s: state=%0d vld=%b, expected state=%0d vld=%b",
               e.nm, state, vld, e.st, e.v);
    end
    auth_pwr = 1'b0;
    tick();
    n_cmp++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL fault_exit: state=%0d fault=%b, expected state=0 fault=0", state, fault);
    end
  endtask

  task automatic test_rider_leave();
    reach_steer();
    n_cmp++;
    if (state !== 3'd3) begin
      n_err++;
      $display("FAIL leave_setup: state=%0d, expected 3", state);
    end
    auth_pwr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe(1'b0, 1'b0, (i == 7) ? 3'd0 : 3'd3, 1'b1, "rider_leave");
      e = sb.pop_front();
      n_cmp++;
      if (state !== e.st || vld !== e.v) begin
        n_err++;
        $display("FAIL %s[%0d]: state=%0d vld=%b, expected state=%0d vld=%b",
                 e.nm, i, state, vld, e.st, e.v);
      end
    end
    auth_pwr = 1'b1;
    tick();
    // 7 on + 1 off, then 7 on stays in WAIT; only the 8th of a fresh run enters.
    for (int i = 0; i < 16; i++) begin
      strobe(i != 7, 1'b0, (i == 15) ? 3'd2 : 3'd1, 1'b0, "no_entry");
      e = sb.pop_front();
      n_cmp++;
      if (state !== e.st || vld !== e.v) begin
        n_err++;
        $display("FAIL %s[%0d]: state=%0d vld=%b, expected state=%0d vld=%b",
                 e.nm, i, state, vld, e.st, e.v);
      end
    end
  endtask

  task automatic test_priority();
    auth_pwr = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (state !== 3'd2 || pwr_up !== 1'b1) begin
      n_err++;
      $display("FAIL auth_off_rider_on: state=%0d pwr_up=%b, expected state=2 pwr_up=1",
               state, pwr_up);
    end
    auth_pwr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      strobe(1'b0, i >= 4, (i == 7) ? 3'd4 : 3'd2, 1'b1, "fault_over_off");
      e = sb.pop_front();
      n_cmp++;
      if (state !== e.st || vld !== e.v) begin
        n_err++;
        $display("FAIL %s[%0d]: state=%0d vld=%b, expected state=%0d vld=%b",
                 e.nm, i, state, vld, e.st, e.v);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (state !== 3'd0 || {pwr_up, rider_off, en_steer, fault} !== outs(3'd0) || vld !== 1'b0) begin
      n_err++;
      $display("FAIL rst_from_fault: state=%0d fault=%b vld=%b, expected state=0 fault=0 vld=0",
               state, fault, vld);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 3'd1, 1'b0, "mid_count");
    while (sb.size() > 0) begin
      e = sb.pop_front();
    end
    n_cmp++;
    if (state !== 3'd1) begin
      n_err++;
      $display("FAIL mid_count: state=%0d, expected 1", state);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (state !== 3'd0) begin
      n_err++;
      $display("FAIL rst_from_wait: state=%0d, expected 0", state);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, 1'b0, (i == 7) ? 3'd2 : 3'd1, 1'b0, "reentry");
      e = sb.pop_front();
      n_cmp++;
      if (state !== e.st || vld !== e.v) begin
        n_err++;
        $display("FAIL %s[%0d]: state=%0d vld=%b, expected state=%0d vld=%b",
                 e.nm, i, state, vld, e.st, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_steer_timer();
    test_fault();
    test_rider_leave();
    test_priority();
    test_back_to_back_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
